// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: EX/MEM/WB control-bundle pipeline with RAW-hazard stall, multi-cycle FPU hold and redirect squash; ID->EX latency 1 cycle.
// Backpressure: stall_ifid holds PC and IF/ID on a hazard; define PIPE_CTRL_FWD_EN when a bypass network exists (only load-use and busy stall).
module pipe_ctrl_seq #(
    parameter int CTRL_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MDIV_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              id_fpsrc,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwe,
    input  logic              id_fpdest,
    input  logic              id_load,
    input  logic              id_mdiv,
    input  logic              ex_redirect,
    output logic              stall_ifid,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic              fpu_busy
);

    localparam int CNT_W = $clog2(MDIV_LAT);

    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwe;
    logic              ex_fpdest;
    logic              ex_load;
    logic [CNT_W-1:0]  count;

    logic busy;
    logic hit_ex;
    logic data_haz;
    logic take_id;

    // A producer matches a source when it will write that exact register; GPR r0 is hard-wired.
    function automatic logic src_hit(
        input logic              s_valid,
        input logic              s_regwe,
        input logic              s_fpdest,
        input logic [REG_AW-1:0] s_rd,
        input logic [REG_AW-1:0] rs,
        input logic              src_used,
        input logic              fpsrc
    );
        return s_valid && s_regwe && src_used && (rs == s_rd) &&
               (fpsrc == s_fpdest) && (s_fpdest || (s_rd != '0));
    endfunction

    assign busy     = (count != '0);
    assign fpu_busy = busy;

    assign hit_ex = id_valid &&
                    (src_hit(ex_valid, ex_regwe, ex_fpdest, ex_rd, id_rs1, id_use1, id_fpsrc) ||
                     src_hit(ex_valid, ex_regwe, ex_fpdest, ex_rd, id_rs2, id_use2, id_fpsrc));

`ifdef PIPE_CTRL_FWD_EN
    assign data_haz = hit_ex && ex_load;
`else
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwe;
    logic              mem_fpdest;
    logic              hit_mem;

    // Without bypass a consumer waits until its producer reaches WB (WB writes in the first half-cycle).
    assign hit_mem = id_valid &&
                     (src_hit(mem_valid, mem_regwe, mem_fpdest, mem_rd, id_rs1, id_use1, id_fpsrc) ||
                      src_hit(mem_valid, mem_regwe, mem_fpdest, mem_rd, id_rs2, id_use2, id_fpsrc));
    assign data_haz = hit_ex || hit_mem;
`endif

    assign stall_ifid = (busy || data_haz) && !ex_redirect;
    assign take_id    = id_valid && !ex_redirect && !data_haz;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rd     <= '0;
            ex_regwe  <= 1'b0;
            ex_fpdest <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            count     <= '0;
`ifndef PIPE_CTRL_FWD_EN
            mem_rd     <= '0;
            mem_regwe  <= 1'b0;
            mem_fpdest <= 1'b0;
`endif
        end else if (busy) begin
            // EX holds the FPU op; MEM receives bubbles until the count drains.
            count     <= count - 1'b1;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
`ifndef PIPE_CTRL_FWD_EN
            mem_rd     <= '0;
            mem_regwe  <= 1'b0;
            mem_fpdest <= 1'b0;
`endif
        end else begin
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
`ifndef PIPE_CTRL_FWD_EN
            mem_rd     <= ex_rd;
            mem_regwe  <= ex_regwe;
            mem_fpdest <= ex_fpdest;
`endif
            ex_valid  <= take_id;
            ex_ctrl   <= take_id ? id_ctrl : '0;
            ex_rd     <= take_id ? id_rd : '0;
            ex_regwe  <= take_id && id_regwe;
            ex_fpdest <= take_id && id_fpdest;
            ex_load   <= take_id && id_load;
            if (take_id && id_mdiv) begin
                count <= CNT_W'(MDIV_LAT - 1);
            end
        end
    end

`ifndef SYNTHESIS
    // A held FPU op is never a branch, so a redirect while busy means the front end is confused.
    always_ff @(posedge clock) begin
        if (!reset) begin
            redirect_while_busy: assert (!(ex_redirect && busy));
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Bench for pipe_ctrl_seq: directed scenarios plus a randomized run against an issue-timing scoreboard.
module tb_pipe_ctrl_seq;

    localparam int CTRL_W   = 32;
    localparam int REG_AW   = 5;
    localparam int MDIV_LAT = 4;
`ifdef PIPE_CTRL_FWD_EN
    localparam int LU_STALLS = 1;
`else
    localparam int LU_STALLS = 2;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic              id_fpsrc;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwe;
    logic              id_fpdest;
    logic              id_load;
    logic              id_mdiv;
    logic              ex_redirect;
    logic              stall_ifid;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic              fpu_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit                valid;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        bit                use1;
        bit                use2;
        bit                fpsrc;
        bit                regwe;
        bit                fpdest;
        bit                load;
        bit                mdiv;
    } instr_t;

    pipe_ctrl_seq #(.CTRL_W(CTRL_W), .REG_AW(REG_AW), .MDIV_LAT(MDIV_LAT)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_fpsrc(id_fpsrc), .id_rd(id_rd), .id_regwe(id_regwe), .id_fpdest(id_fpdest),
        .id_load(id_load), .id_mdiv(id_mdiv), .ex_redirect(ex_redirect),
        .stall_ifid(stall_ifid), .ex_valid(ex_valid), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .fpu_busy(fpu_busy)
    );

    always #5 clock = ~clock;

    function automatic instr_t nop();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t mk(input logic [CTRL_W-1:0] c, input logic [REG_AW-1:0] rd,
                                  input bit regwe, input bit fpdest, input bit load, input bit mdiv,
                                  input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                                  input bit use1, input bit use2, input bit fpsrc);
        instr_t i;
        i.valid = 1'b1; i.ctrl = c; i.rd = rd; i.regwe = regwe; i.fpdest = fpdest;
        i.load = load; i.mdiv = mdiv; i.rs1 = rs1; i.rs2 = rs2;
        i.use1 = use1; i.use2 = use2; i.fpsrc = fpsrc;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid  = ($urandom_range(0, 9) != 0);
        i.ctrl   = CTRL_W'($urandom());
        i.rd     = REG_AW'($urandom_range(0, 3));
        i.rs1    = REG_AW'($urandom_range(0, 3));
        i.rs2    = REG_AW'($urandom_range(0, 3));
        i.use1   = i.valid && ($urandom_range(0, 1) == 1);
        i.use2   = i.valid && ($urandom_range(0, 1) == 1);
        i.fpsrc  = ($urandom_range(0, 1) == 1);
        i.fpdest = ($urandom_range(0, 1) == 1);
        i.regwe  = ($urandom_range(0, 4) != 0);
        i.mdiv   = ($urandom_range(0, 9) == 0);
        i.load   = !i.mdiv && ($urandom_range(0, 3) == 0);
        if (i.mdiv) begin
            i.fpdest = 1'b1;
            i.regwe  = 1'b1;
        end
        return i;
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.valid; id_ctrl = i.ctrl; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use1 = i.use1; id_use2 = i.use2; id_fpsrc = i.fpsrc; id_rd = i.rd;
        id_regwe = i.regwe; id_fpdest = i.fpdest; id_load = i.load; id_mdiv = i.mdiv;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_redirect = 1'b0;
        drive(nop());
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_redirect = 1'b0;
        drive(mk(32'hDEAD_BEEF, 5'd3, 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b expected 000", {ex_valid, mem_valid, wb_valid}); end
            checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== '0) begin errors++; $display("FAIL reset_ctrl: got %h/%h/%h expected 0", ex_ctrl, mem_ctrl, wb_ctrl); end
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (stall_ifid !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_ifid); end
        checks++; if (fpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", fpu_busy); end
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL reset_after_valids: got %b expected 000", {ex_valid, mem_valid, wb_valid}); end
    endtask

    task automatic test_load_use();
        instr_t lw, add;
        int stalls;
        lw  = mk(32'h1000_0001, 5'd3, 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        add = mk(32'h2000_0002, 5'd4, 1, 0, 0, 0, 5'd3, 5'd5, 1, 1, 0);
        do_reset();
        drive(lw);
        @(posedge clock); #1;
        drive(add);
        stalls = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k > 0) begin
                checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: ex_valid got %b expected 0", ex_valid); end
            end
            if (k == 1) begin
                checks++; if (mem_ctrl !== 32'h1000_0001) begin errors++; $display("FAIL lu_mem: mem_ctrl got %h expected 10000001", mem_ctrl); end
            end
            if (!stall_ifid) break;
            stalls++;
            @(posedge clock); #1;
        end
        checks++; if (stalls != LU_STALLS) begin errors++; $display("FAIL lu_stalls: got %0d expected %0d", stalls, LU_STALLS); end
        @(posedge clock); #1;
        drive(nop());
        @(negedge clock);
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 32'h2000_0002) begin errors++; $display("FAIL lu_add_ex: got v=%b ctrl=%h expected v=1 ctrl=20000002", ex_valid, ex_ctrl); end
    endtask

    task automatic test_r0_file();
        do_reset();
        drive(mk(32'h3000_0003, 5'd0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0));
        @(posedge clock); #1;
        drive(mk(32'h3000_0004, 5'd4, 1, 0, 0, 0, 5'd0, 5'd0, 1, 1, 0));
        @(negedge clock);
        checks++; if (stall_ifid !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b expected 0", stall_ifid); end
        @(posedge clock); #1;
        drive(mk(32'h3000_0005, 5'd3, 1, 1, 1, 0, 5'd0, 5'd0, 0, 0, 0));
        @(posedge clock); #1;
        drive(mk(32'h3000_0006, 5'd6, 1, 0, 0, 0, 5'd3, 5'd3, 1, 1, 0));
        @(negedge clock);
        checks++; if (stall_ifid !== 1'b0) begin errors++; $display("FAIL file_stall: got %b expected 0", stall_ifid); end
        checks++; if (ex_ctrl !== 32'h3000_0005) begin errors++; $display("FAIL file_lf_ex: got %h expected 30000005", ex_ctrl); end
        @(posedge clock); #1;
        drive(nop());
        @(negedge clock);
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 32'h3000_0006) begin errors++; $display("FAIL file_add_ex: got v=%b ctrl=%h expected v=1 ctrl=30000006", ex_valid, ex_ctrl); end
    endtask

    task automatic test_mdiv();
        int busy_cycles;
        do_reset();
        drive(mk(32'h4000_00CC, 5'd1, 1, 1, 0, 1, 5'd0, 5'd0, 0, 0, 1));
        @(negedge clock);
        checks++; if (stall_ifid !== 1'b0) begin errors++; $display("FAIL mdiv_issue_stall: got %b expected 0", stall_ifid); end
        @(posedge clock); #1;
        drive(mk(32'h4000_00DD, 5'd7, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0));
        busy_cycles = 0;
        for (int k = 1; k <= MDIV_LAT + 1; k++) begin
            @(negedge clock);
            if (fpu_busy === 1'b1) busy_cycles++;
            checks++; if (stall_ifid !== (k < MDIV_LAT)) begin errors++; $display("FAIL mdiv_stall c%0d: got %b expected %b", k, stall_ifid, (k < MDIV_LAT)); end
            if (k <= MDIV_LAT) begin
                checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 32'h4000_00CC) begin errors++; $display("FAIL mdiv_hold c%0d: got v=%b ctrl=%h expected v=1 ctrl=400000cc", k, ex_valid, ex_ctrl); end
            end else begin
                checks++; if (ex_ctrl !== 32'h4000_00DD || mem_valid !== 1'b1 || mem_ctrl !== 32'h4000_00CC) begin errors++; $display("FAIL mdiv_leave: got ex=%h mem_v=%b mem=%h expected ex=400000dd mem_v=1 mem=400000cc", ex_ctrl, mem_valid, mem_ctrl); end
            end
            if (k >= 2 && k <= MDIV_LAT) begin
                checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL mdiv_mem_bubble c%0d: got %b expected 0", k, mem_valid); end
            end
            @(posedge clock); #1;
            if (k == MDIV_LAT) drive(nop());
        end
        checks++; if (busy_cycles != MDIV_LAT - 1) begin errors++; $display("FAIL mdiv_busy_cycles: got %0d expected %0d", busy_cycles, MDIV_LAT - 1); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(mk(32'h5000_0001, 5'd3, 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0));
        @(posedge clock); #1;
        drive(mk(32'h5000_0002, 5'd4, 1, 0, 0, 0, 5'd3, 5'd0, 1, 0, 0));
        ex_redirect = 1'b1;
        @(negedge clock);
        checks++; if (stall_ifid !== 1'b0) begin errors++; $display("FAIL redir_stall: got %b expected 0", stall_ifid); end
        @(posedge clock); #1;
        ex_redirect = 1'b0;
        drive(mk(32'h5000_0003, 5'd5, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0));
        @(negedge clock);
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin errors++; $display("FAIL redir_bubble: got v=%b ctrl=%h expected v=0 ctrl=0", ex_valid, ex_ctrl); end
        checks++; if (mem_valid !== 1'b1 || mem_ctrl !== 32'h5000_0001) begin errors++; $display("FAIL redir_adv: got v=%b ctrl=%h expected v=1 ctrl=50000001", mem_valid, mem_ctrl); end
        @(posedge clock); #1;
        drive(nop());
        @(negedge clock);
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 32'h5000_0003) begin errors++; $display("FAIL redir_target: got v=%b ctrl=%h expected v=1 ctrl=50000003", ex_valid, ex_ctrl); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive(mk(32'h6000_00CC, 5'd1, 1, 1, 0, 1, 5'd0, 5'd0, 0, 0, 1));
        @(posedge clock); #1;
        drive(nop());
        @(posedge clock);
        @(negedge clock);
        checks++; if (fpu_busy !== 1'b1) begin errors++; $display("FAIL rb_busy_before: got %b expected 1", fpu_busy); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (fpu_busy !== 1'b0) begin errors++; $display("FAIL rb_busy_after: got %b expected 0", fpu_busy); end
        checks++; if ({ex_valid, mem_valid, wb_valid, stall_ifid} !== 4'b0000) begin errors++; $display("FAIL rb_empty: got %b expected 0000", {ex_valid, mem_valid, wb_valid, stall_ifid}); end
        @(posedge clock);
        @(negedge clock);
        checks++; if ({ex_valid, mem_valid, wb_valid, fpu_busy} !== 4'b0000) begin errors++; $display("FAIL rb_stays_empty: got %b expected 0000", {ex_valid, mem_valid, wb_valid, fpu_busy}); end
    endtask

    // Scoreboard: each issue books the cycles its bundle occupies EX/MEM/WB and the first
    // cycle a consumer of its destination may leave ID; EX is free again after its residency.
    task automatic test_random(input int ncyc);
        int ready [64];
        bit exp_ev [1024];
        bit exp_mv [1024];
        bit exp_wv [1024];
        logic [CTRL_W-1:0] exp_ec [1024];
        logic [CTRL_W-1:0] exp_mc [1024];
        logic [CTRL_W-1:0] exp_wc [1024];
        instr_t cur;
        bit have, busy, redir, haz, exp_stall;
        int ex_free, lat, rdy, key;
        for (int i = 0; i < 64; i++) ready[i] = 0;
        for (int t = 0; t < 1024; t++) begin
            exp_ev[t] = 0; exp_mv[t] = 0; exp_wv[t] = 0;
            exp_ec[t] = '0; exp_mc[t] = '0; exp_wc[t] = '0;
        end
        ex_free = 0;
        have = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!have) begin
                cur = rand_instr();
                have = 1;
            end
            busy  = (c < ex_free);
            redir = !busy && ($urandom_range(0, 11) == 0);
            drive(cur);
            ex_redirect = redir;
            haz = 0;
            if (cur.valid) begin
                if (cur.use1 && (cur.fpsrc || cur.rs1 != 0) && ready[{cur.fpsrc, cur.rs1}] > c) haz = 1;
                if (cur.use2 && (cur.fpsrc || cur.rs2 != 0) && ready[{cur.fpsrc, cur.rs2}] > c) haz = 1;
            end
            exp_stall = !redir && (busy || haz);
            @(negedge clock);
            checks++; if (stall_ifid !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall_ifid, exp_stall); end
            checks++; if (fpu_busy !== busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, fpu_busy, busy); end
            checks++; if (ex_valid !== exp_ev[c] || ex_ctrl !== exp_ec[c]) begin errors++; $display("FAIL rnd_ex c%0d: got v=%b ctrl=%h expected v=%b ctrl=%h", c, ex_valid, ex_ctrl, exp_ev[c], exp_ec[c]); end
            checks++; if (mem_valid !== exp_mv[c] || mem_ctrl !== exp_mc[c]) begin errors++; $display("FAIL rnd_mem c%0d: got v=%b ctrl=%h expected v=%b ctrl=%h", c, mem_valid, mem_ctrl, exp_mv[c], exp_mc[c]); end
            checks++; if (wb_valid !== exp_wv[c] || wb_ctrl !== exp_wc[c]) begin errors++; $display("FAIL rnd_wb c%0d: got v=%b ctrl=%h expected v=%b ctrl=%h", c, wb_valid, wb_ctrl, exp_wv[c], exp_wc[c]); end
            if (!exp_stall) begin
                if (!redir && cur.valid) begin
                    lat = cur.mdiv ? MDIV_LAT : 1;
                    for (int t = c + 1; t <= c + lat; t++) begin
                        exp_ev[t] = 1; exp_ec[t] = cur.ctrl;
                    end
                    exp_mv[c + lat + 1] = 1; exp_mc[c + lat + 1] = cur.ctrl;
                    exp_wv[c + lat + 2] = 1; exp_wc[c + lat + 2] = cur.ctrl;
                    ex_free = c + lat;
                    if (cur.regwe && (cur.fpdest || cur.rd != 0)) begin
`ifdef PIPE_CTRL_FWD_EN
                        rdy = cur.load ? c + 2 : c + 1;
`else
                        rdy = c + lat + 2;
`endif
                        key = {cur.fpdest, cur.rd};
                        if (rdy > ready[key]) ready[key] = rdy;
                    end
                end
                have = 0;
            end
            @(posedge clock); #1;
        end
        ex_redirect = 1'b0;
        drive(nop());
    endtask

    initial begin
        reset = 1'b1;
        ex_redirect = 1'b0;
        drive(nop());
        test_reset();
        test_load_use();
        test_r0_file();
        test_mdiv();
        test_redirect();
        test_reset_busy();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
